// File: rtl/mic_defs.sv
// rtl/mic_defs.sv - shared MIC header field positions, FSM encodings and header builder
package mic_defs;

    localparam int HDR_BEATS_HI = 63;
    localparam int HDR_BEATS_LO = 56;
    localparam int HDR_RNW      = 55;
    localparam int HDR_BE_HI    = 54;
    localparam int HDR_BE_LO    = 50;
    localparam int HDR_ERR      = 49;
    localparam int HDR_SRC_HI   = 47;
    localparam int HDR_SRC_LO   = 40;
    localparam int HDR_ADDR_HI  = 31;
    localparam int HDR_ADDR_LO  = 3;

    localparam logic [4:0] MIC_BE_FULL = 5'h1f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_WDATA = 3'd2,
        ST_WACK  = 3'd3,
        ST_RHDR  = 3'd4,
        ST_RDATA = 3'd5
    } mic_m_state_t;

    function automatic logic [63:0] mic_req_hdr(
        input logic [7:0]  beats,
        input logic        rnw,
        input logic [4:0]  be,
        input logic [7:0]  src,
        input logic [28:0] addr
    );
        logic [63:0] h;
        h = '0;
        h[HDR_BEATS_HI:HDR_BEATS_LO] = beats;
        h[HDR_RNW]                   = rnw;
        h[HDR_BE_HI:HDR_BE_LO]       = be;
        h[HDR_SRC_HI:HDR_SRC_LO]     = src;
        h[HDR_ADDR_HI:HDR_ADDR_LO]   = addr;
        return h;
    endfunction

endpackage

// File: rtl/mic_beat_ctr.sv
// rtl/mic_beat_ctr.sv - 8-bit loadable down-counter with zero flag
module mic_beat_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/mic_m_bridge.sv
// rtl/mic_m_bridge.sv - MIC master endpoint: CPU request handshake to MIC packets and back
module mic_m_bridge
    import mic_defs::*;
#(
    parameter logic [31:0] NAME   = "MICM",
    parameter logic [7:0]  SRC_ID = 8'h00
) (
    input  logic        clk,
    input  logic        reset,

    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST,

    input  logic        I_TVALID,
    output logic        I_TREADY,
    input  logic [63:0] I_TDATA,
    input  logic        I_TLAST,

    output logic        req_ready,
    input  logic        req_start,
    input  logic        req_RnW,
    input  logic [7:0]  req_beats,
    input  logic [28:0] req_address,
    input  logic [4:0]  req_byte_enables,

    output logic [63:0] read_data,
    output logic        read_data_valid,
    input  logic        read_data_ready,

    input  logic [63:0] write_data,
    input  logic        write_data_valid,
    output logic        write_data_ready
);

    mic_m_state_t state_q, state_d;

    logic        rnw_q;
    logic [7:0]  beats_q;
    logic [4:0]  be_q;
    logic [28:0] addr_q;

    logic        err_dbg;
    logic        len_mismatch_dbg;

    logic        start_accept;
    logic        wdata_fire;
    logic        rdata_fire;
    logic        rhdr_fire;
    logic        wack_fire;
    logic [7:0]  ctr_count;
    logic        ctr_zero;

    assign start_accept = (state_q == ST_IDLE) && req_start;
    assign wdata_fire   = (state_q == ST_WDATA) && write_data_valid && O_TREADY;
    assign rdata_fire   = (state_q == ST_RDATA) && I_TVALID && read_data_ready;
    assign rhdr_fire    = (state_q == ST_RHDR) && I_TVALID;
    assign wack_fire    = (state_q == ST_WACK) && I_TVALID;

    mic_beat_ctr u_beat_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (start_accept),
        .load_value (req_beats),
        .dec        (wdata_fire || rdata_fire),
        .count      (ctr_count),
        .zero       (ctr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnw_q   <= 1'b0;
            beats_q <= 8'd0;
            be_q    <= 5'd0;
            addr_q  <= 29'd0;
        end else if (start_accept) begin
            rnw_q   <= req_RnW;
            beats_q <= req_beats;
            be_q    <= req_byte_enables;
            addr_q  <= req_address;
        end
    end

    // Debug only: response error bit and burst-length disagreement never steer the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_dbg          <= 1'b0;
            len_mismatch_dbg <= 1'b0;
        end else begin
            if (rhdr_fire || wack_fire) begin
                err_dbg <= I_TDATA[HDR_ERR];
            end
            if (start_accept) begin
                len_mismatch_dbg <= 1'b0;
            end else if (rdata_fire && (I_TLAST != ctr_zero)) begin
                len_mismatch_dbg <= 1'b1;
            end
        end
    end

    assign read_data = I_TDATA;

    always_comb begin
        state_d          = state_q;
        O_TVALID         = 1'b0;
        O_TDATA          = 64'd0;
        O_TLAST          = 1'b0;
        I_TREADY         = 1'b0;
        req_ready        = 1'b0;
        read_data_valid  = 1'b0;
        write_data_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_start) begin
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                O_TVALID = 1'b1;
                O_TDATA  = mic_req_hdr(beats_q, rnw_q, be_q, SRC_ID, addr_q);
                O_TLAST  = rnw_q;
                if (O_TREADY) begin
                    state_d = rnw_q ? ST_RHDR : ST_WDATA;
                end
            end

            ST_WDATA: begin
                O_TVALID = write_data_valid;
                O_TDATA  = write_data;
                O_TLAST  = ctr_zero;
                if (wdata_fire) begin
                    write_data_ready = 1'b1;
                    if (ctr_zero) begin
                        state_d = ST_WACK;
                    end
                end
            end

            ST_WACK: begin
                I_TREADY = 1'b1;
                if (I_TVALID) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RHDR: begin
                I_TREADY = 1'b1;
                // A header-only response (error or short) ends the read with no data.
                if (I_TVALID) begin
                    state_d = I_TLAST ? ST_IDLE : ST_RDATA;
                end
            end

            ST_RDATA: begin
                I_TREADY = read_data_ready;
                if (rdata_fire) begin
                    read_data_valid = 1'b1;
                    if (I_TLAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{NAME, err_dbg, len_mismatch_dbg, ctr_count};

endmodule

// File: tb/tb_mic_m_bridge.sv
// tb/tb_mic_m_bridge.sv - directed self-checking bench for mic_m_bridge
module tb_mic_m_bridge;
    import mic_defs::*;

    logic        clk;
    logic        reset;
    logic        O_TVALID, O_TREADY, O_TLAST;
    logic [63:0] O_TDATA;
    logic        I_TVALID, I_TREADY, I_TLAST;
    logic [63:0] I_TDATA;
    logic        req_ready, req_start, req_RnW;
    logic [7:0]  req_beats;
    logic [28:0] req_address;
    logic [4:0]  req_byte_enables;
    logic [63:0] read_data;
    logic        read_data_valid, read_data_ready;
    logic [63:0] write_data;
    logic        write_data_valid, write_data_ready;

    int checks = 0;
    int errors = 0;

    mic_m_bridge #(.NAME("MICM"), .SRC_ID(8'h00)) dut (
        .clk              (clk),
        .reset            (reset),
        .O_TVALID         (O_TVALID),
        .O_TREADY         (O_TREADY),
        .O_TDATA          (O_TDATA),
        .O_TLAST          (O_TLAST),
        .I_TVALID         (I_TVALID),
        .I_TREADY         (I_TREADY),
        .I_TDATA          (I_TDATA),
        .I_TLAST          (I_TLAST),
        .req_ready        (req_ready),
        .req_start        (req_start),
        .req_RnW          (req_RnW),
        .req_beats        (req_beats),
        .req_address      (req_address),
        .req_byte_enables (req_byte_enables),
        .read_data        (read_data),
        .read_data_valid  (read_data_valid),
        .read_data_ready  (read_data_ready),
        .write_data       (write_data),
        .write_data_valid (write_data_valid),
        .write_data_ready (write_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_req(input logic rnw, input logic [7:0] beats,
                             input logic [28:0] addr, input logic [4:0] be);
        req_RnW          = rnw;
        req_beats        = beats;
        req_address      = addr;
        req_byte_enables = be;
        req_start        = 1'b1;
        step();
        req_start        = 1'b0;
        req_RnW          = ~rnw;
        req_beats        = 8'h5a;
        req_address      = 29'h1555_5555;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        checks++; if (O_TVALID !== 1'b0)        begin errors++; $display("FAIL reset_o_tvalid got %b want 0", O_TVALID); end
        checks++; if (O_TLAST !== 1'b0)         begin errors++; $display("FAIL reset_o_tlast got %b want 0", O_TLAST); end
        checks++; if (O_TDATA !== 64'd0)        begin errors++; $display("FAIL reset_o_tdata got %h want 0", O_TDATA); end
        checks++; if (I_TREADY !== 1'b0)        begin errors++; $display("FAIL reset_i_tready got %b want 0", I_TREADY); end
        checks++; if (req_ready !== 1'b1)       begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", read_data_valid); end
        checks++; if (write_data_ready !== 1'b0) begin errors++; $display("FAIL reset_wdr got %b want 0", write_data_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read(input logic [63:0] d);
        start_req(1'b1, 8'h00, 29'h247, 5'h11);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rd_req_ready_low got %b want 0", req_ready); end
        checks++; if (O_TVALID !== 1'b1)  begin errors++; $display("FAIL rd_hdr_valid got %b want 1", O_TVALID); end
        checks++; if (O_TDATA !== 64'h00C4_0000_0000_1238) begin errors++; $display("FAIL rd_hdr_data got %h want 00c4000000001238", O_TDATA); end
        checks++; if (O_TLAST !== 1'b1)   begin errors++; $display("FAIL rd_hdr_last got %b want 1", O_TLAST); end
        step();
        #1;
        checks++; if (O_TVALID !== 1'b1 || O_TDATA !== 64'h00C4_0000_0000_1238) begin errors++; $display("FAIL rd_hdr_hold got %b/%h want 1/00c4000000001238", O_TVALID, O_TDATA); end
        O_TREADY = 1'b1;
        step();
        O_TREADY = 1'b0;
        req_start = 1'b1;
        #1;
        checks++; if (I_TREADY !== 1'b1 || O_TVALID !== 1'b0) begin errors++; $display("FAIL rd_rhdr got itready %b otvalid %b want 1/0", I_TREADY, O_TVALID); end
        I_TVALID        = 1'b1;
        I_TDATA         = 64'h0080_0000_0000_0000;
        I_TLAST         = 1'b0;
        read_data_ready = 1'b1;
        step();
        req_start = 1'b0;
        I_TDATA   = d;
        I_TLAST   = 1'b1;
        #1;
        checks++; if (read_data_valid !== 1'b1) begin errors++; $display("FAIL rd_data_valid got %b want 1", read_data_valid); end
        checks++; if (read_data !== d)          begin errors++; $display("FAIL rd_data got %h want %h", read_data, d); end
        step();
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || read_data_valid !== 1'b0) begin errors++; $display("FAIL rd_done got ready %b rdv %b want 1/0", req_ready, read_data_valid); end
    endtask

    task automatic test_write4();
        int i = 0;
        int pulses = 0;
        int lasts = 0;
        start_req(1'b0, 8'd3, 29'h20, MIC_BE_FULL);
        checks++; if (O_TDATA !== 64'h037C_0000_0000_0100 || O_TLAST !== 1'b0) begin errors++; $display("FAIL wr4_hdr got %h last %b want 037c000000000100/0", O_TDATA, O_TLAST); end
        O_TREADY = 1'b1;
        step();
        write_data_valid = 1'b1;
        for (int c = 0; c < 16 && i < 4; c++) begin
            O_TREADY   = (c % 2 == 0);
            write_data = 64'hA5A5_0000_0000_0000 + 64'(i);
            #1;
            checks++; if (O_TVALID !== 1'b1) begin errors++; $display("FAIL wr4_valid beat %0d got %b want 1", i, O_TVALID); end
            checks++; if (O_TDATA !== 64'hA5A5_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL wr4_data beat %0d got %h", i, O_TDATA); end
            checks++; if (O_TLAST !== (i == 3)) begin errors++; $display("FAIL wr4_last beat %0d got %b want %b", i, O_TLAST, (i == 3)); end
            checks++; if (write_data_ready !== O_TREADY) begin errors++; $display("FAIL wr4_wdr beat %0d got %b want %b", i, write_data_ready, O_TREADY); end
            if (write_data_ready === 1'b1) pulses++;
            if (O_TLAST === 1'b1 && O_TREADY) lasts++;
            if (O_TREADY) i++;
            step();
        end
        write_data_valid = 1'b0;
        O_TREADY = 1'b0;
        #1;
        checks++; if (pulses != 4 || lasts != 1) begin errors++; $display("FAIL wr4_counts got pulses %0d lasts %0d want 4/1", pulses, lasts); end
        checks++; if (I_TREADY !== 1'b1 || O_TVALID !== 1'b0) begin errors++; $display("FAIL wr4_wack got itready %b otvalid %b want 1/0", I_TREADY, O_TVALID); end
        I_TVALID = 1'b1;
        I_TLAST  = 1'b1;
        I_TDATA  = 64'd0;
        step();
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr4_idle got %b want 1", req_ready); end
    endtask

    task automatic test_read_stall();
        int j = 0;
        logic rdr;
        start_req(1'b1, 8'd3, 29'h40, MIC_BE_FULL);
        checks++; if (O_TDATA !== 64'h03FC_0000_0000_0200) begin errors++; $display("FAIL rd4_hdr got %h want 03fc000000000200", O_TDATA); end
        O_TREADY = 1'b1;
        step();
        O_TREADY        = 1'b0;
        I_TVALID        = 1'b1;
        I_TDATA         = 64'h0080_0000_0000_0000;
        I_TLAST         = 1'b0;
        read_data_ready = 1'b1;
        step();
        for (int c = 0; c < 20 && j < 4; c++) begin
            rdr             = !(c >= 1 && c <= 3);
            read_data_ready = rdr;
            I_TDATA         = 64'hC0DE_0000_0000_0000 + 64'(j);
            I_TLAST         = (j == 3);
            #1;
            checks++; if (I_TREADY !== rdr)        begin errors++; $display("FAIL rd4_itready cyc %0d got %b want %b", c, I_TREADY, rdr); end
            checks++; if (read_data_valid !== rdr) begin errors++; $display("FAIL rd4_rdv cyc %0d got %b want %b", c, read_data_valid, rdr); end
            if (read_data_valid === 1'b1) begin
                checks++; if (read_data !== 64'hC0DE_0000_0000_0000 + 64'(j)) begin errors++; $display("FAIL rd4_data beat %0d got %h", j, read_data); end
                j++;
            end
            step();
        end
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
        #1;
        checks++; if (j != 4 || req_ready !== 1'b1) begin errors++; $display("FAIL rd4_done got beats %0d ready %b want 4/1", j, req_ready); end
    endtask

    task automatic test_error_resp();
        start_req(1'b1, 8'd0, 29'h10, MIC_BE_FULL);
        O_TREADY = 1'b1;
        step();
        O_TREADY        = 1'b0;
        I_TVALID        = 1'b1;
        I_TDATA         = 64'h0082_0000_0000_0000;
        I_TLAST         = 1'b1;
        read_data_ready = 1'b1;
        #1;
        checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL err_rdv got %b want 0", read_data_valid); end
        step();
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL err_idle got %b want 1", req_ready); end
        checks++; if (dut.err_dbg !== 1'b1) begin errors++; $display("FAIL err_dbg got %b want 1", dut.err_dbg); end
    endtask

    task automatic test_reset_mid_write();
        start_req(1'b0, 8'd3, 29'h20, MIC_BE_FULL);
        O_TREADY = 1'b1;
        step();
        write_data_valid = 1'b1;
        write_data       = 64'h1;
        step();
        O_TREADY   = 1'b0;
        write_data = 64'h2;
        #1;
        checks++; if (O_TVALID !== 1'b1 || O_TLAST !== 1'b0) begin errors++; $display("FAIL rst_mid_beat2 got valid %b last %b want 1/0", O_TVALID, O_TLAST); end
        reset = 1'b1;
        step();
        #1;
        checks++; if (O_TVALID !== 1'b0)  begin errors++; $display("FAIL rst_mid_otvalid got %b want 0", O_TVALID); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready got %b want 1", req_ready); end
        reset            = 1'b0;
        write_data_valid = 1'b0;
        step();
        test_single_read(64'h0BAD_F00D_CAFE_1234);
    endtask

    task automatic test_write256();
        int n = 0;
        int bad = 0;
        int lasts = 0;
        int last_at = -1;
        start_req(1'b0, 8'hff, 29'h40, MIC_BE_FULL);
        checks++; if (O_TDATA !== 64'hFF7C_0000_0000_0200) begin errors++; $display("FAIL wr256_hdr got %h want ff7c000000000200", O_TDATA); end
        O_TREADY = 1'b1;
        step();
        write_data_valid = 1'b1;
        for (int c = 0; c < 300 && n < 256; c++) begin
            write_data = 64'(n) ^ 64'h5555_0000_0000_0000;
            #1;
            if (write_data_ready !== 1'b1 || O_TDATA !== (64'(n) ^ 64'h5555_0000_0000_0000)) bad++;
            if (O_TLAST === 1'b1) begin
                lasts++;
                last_at = n;
            end
            if (write_data_ready === 1'b1) n++;
            step();
        end
        write_data_valid = 1'b0;
        O_TREADY = 1'b0;
        #1;
        checks++; if (n != 256)  begin errors++; $display("FAIL wr256_beats got %0d want 256", n); end
        checks++; if (bad != 0)  begin errors++; $display("FAIL wr256_data got %0d bad beats want 0", bad); end
        checks++; if (lasts != 1 || last_at != 255) begin errors++; $display("FAIL wr256_last got %0d lasts at %0d want 1 at 255", lasts, last_at); end
        checks++; if (I_TREADY !== 1'b1) begin errors++; $display("FAIL wr256_wack got %b want 1", I_TREADY); end
        I_TVALID = 1'b1;
        I_TLAST  = 1'b1;
        I_TDATA  = 64'd0;
        step();
        I_TVALID = 1'b0;
        I_TLAST  = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr256_idle got %b want 1", req_ready); end
    endtask

    initial begin
        reset            = 1'b1;
        O_TREADY         = 1'b0;
        I_TVALID         = 1'b0;
        I_TDATA          = 64'd0;
        I_TLAST          = 1'b0;
        req_start        = 1'b0;
        req_RnW          = 1'b0;
        req_beats        = 8'd0;
        req_address      = 29'd0;
        req_byte_enables = 5'd0;
        read_data_ready  = 1'b0;
        write_data       = 64'd0;
        write_data_valid = 1'b0;

        test_reset();
        test_single_read(64'hDEAD_BEEF_0123_4567);
        test_write4();
        test_read_stall();
        test_error_resp();
        test_reset_mid_write();
        test_write256();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
